max7219_spi_receiver: RTL

Responder end of the MAX7219 display link: oversamples the three-wire SPI stream (MOSI, CS, clk_SPI) produced by the stopwatch's SPI display driver, assembles 16-bit frames and applies them to a shadow copy of the MAX7219 register file. It provides a registered digit read port and the decoded control state. It serves as a loopback checker on-chip and as the display-side model for system-level benches.

---
 rtl/max7219_pkg.sv | 72 +++++++
 rtl/spi_sync_edge.sv | 53 +++++
 rtl/max7219_spi_receiver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_pkg
//  Description : Shared definitions for the MAX7219 SPI responder. It holds
//                the register address map, the frame geometry, the receive
//                FSM state encoding and, when MAX7219_CODEB_EN is defined,
//                the Code-B font lookup.
//  Macros      : MAX7219_CODEB_EN - compile the Code-B font function
//  Revision    : 1.0 - initial release
// ============================================================================
package max7219_pkg;

  // Register address map (frame bits [11:8])
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // A well-formed frame carries exactly this many bits; the counter stops
  // one above so that any overlong frame stays distinguishable.
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] COUNT_SAT  = 5'd17;

  // Receive FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    FSM_IDLE   = S_IDLE,
    FSM_SHIFT  = S_SHIFT,
    FSM_COMMIT = S_COMMIT
  } fsm_state_e;

`ifdef MAX7219_CODEB_EN
  // Code-B font: returns segments A..G in bits [6:0] (A is bit 6).
  function automatic logic [6:0] codeb_font(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h01; // '-'
      4'hB: seg = 7'h4F; // 'E'
      4'hC: seg = 7'h37; // 'H'
      4'hD: seg = 7'h0E; // 'L'
      4'hE: seg = 7'h67; // 'P'
      default: seg = 7'h00; // blank
    endcase
    return seg;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchroniser for one asynchronous SPI wire plus
//                an edge-detect flop producing single-cycle rise/fall strobes.
//                All flops reset to RESET_LEVEL so no edge is reported while
//                the chain holds its idle value.
//  Ports       : clk   - system clock
//                res   - synchronous active-high reset
//                d_in  - asynchronous input pin
//                level - synchronised level
//                rise  - one-cycle strobe on synchronised 0->1
//                fall  - one-cycle strobe on synchronised 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
  import max7219_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/max7219_spi_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_spi_receiver
//  Description : MAX7219 responder. Oversamples MOSI/CS/clk_SPI, assembles
//                16-bit frames and applies them to a shadow register file.
//                Offers a registered digit read port and decoded control
//                state, plus per-frame valid/error pulses.
//  Ports       : clk, res            - system clock, sync active-high reset
//                MOSI, CS, clk_SPI   - asynchronous SPI pins
//                rd_idx / rd_data    - digit read port (registered)
//                intensity, scan_limit, shutdown_n - control registers
//                frame_valid / frame_err - commit / malformed-frame pulses
//                frame_addr / frame_data - last committed frame
//  Macros      : MAX7219_CODEB_EN - Code-B decoding on the read port
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_spi_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       MOSI,
  input  logic       CS,
  input  logic       clk_SPI,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_data,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data
);

  // Synchronised pin views
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
    .clk(clk), .res(res), .d_in(MOSI),
    .level(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .res(res), .d_in(CS),
    .level(w_cs_lvl), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
    .clk(clk), .res(res), .d_in(clk_SPI),
    .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  // After reset the chains still hold their idle values while the pins may
  // not (e.g. CS held low across a reset). Edges are ignored until the chain
  // and edge flop have been refilled from the pins, so a frame interrupted by
  // reset cannot restart until a genuine CS fall.
  localparam logic [2:0] FLUSH_DONE = 3'(SYNC_STAGES + 1);

  logic [2:0] flush_q, flush_d;
  logic       w_edges_en;

  assign w_edges_en = (flush_q == FLUSH_DONE);

  always_comb begin
    flush_d = flush_q;
    if (!w_edges_en) flush_d = flush_q + 3'd1;
  end

  logic w_cs_rise_en, w_cs_fall_en, w_sclk_rise_en;
  assign w_cs_rise_en   = w_cs_rise   & w_edges_en;
  assign w_cs_fall_en   = w_cs_fall   & w_edges_en;
  assign w_sclk_rise_en = w_sclk_rise & w_edges_en;

  // Only the low 12 frame bits carry information; older bits fall off.
  fsm_state_e state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;

  // Shadow register file
  logic [7:0] digit_q [8];
  logic [7:0] digit_d [8];
  logic [7:0] decode_q, decode_d;
  logic [3:0] intensity_q, intensity_d;
  logic [2:0] scan_limit_q, scan_limit_d;
  logic       shutdown_q, shutdown_d;
  logic       test_q, test_d;

  logic       frame_valid_q, frame_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [3:0] frame_addr_q, frame_addr_d;
  logic [7:0] frame_data_q, frame_data_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [2:0] w_digit_idx;

  assign w_addr      = shift_q[11:8];
  assign w_data      = shift_q[7:0];
  // Addresses 1..8 map to digit slots 0..7; 3-bit wrap turns 8 into 7.
  assign w_digit_idx = w_addr[2:0] - 3'd1;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    count_d       = count_q;
    digit_d       = digit_q;
    decode_d      = decode_q;
    intensity_d   = intensity_q;
    scan_limit_d  = scan_limit_q;
    shutdown_d    = shutdown_q;
    test_d        = test_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_addr_d  = frame_addr_q;
    frame_data_d  = frame_data_q;

    case (state_q)
      FSM_IDLE: begin
        // A coincident clk_SPI rise is dropped: the frame starts empty.
        if (w_cs_fall_en) begin
          shift_d = '0;
          count_d = '0;
          state_d = FSM_SHIFT;
        end
      end

      FSM_SHIFT: begin
        // CS rise takes precedence over a coincident clk_SPI rise.
        if (w_cs_rise_en) begin
          state_d = FSM_COMMIT;
        end else if (w_sclk_rise_en) begin
          shift_d = {shift_q[10:0], w_mosi_lvl};
          if (count_q != COUNT_SAT) count_d = count_q + 5'd1;
        end
      end

      FSM_COMMIT: begin
        state_d = FSM_IDLE;
        if (count_q == FRAME_BITS) begin
          frame_valid_d = 1'b1;
          frame_addr_d  = w_addr;
          frame_data_d  = w_data;
          case (w_addr)
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                            digit_d[w_digit_idx] = w_data;
            ADDR_DECODE:    decode_d     = w_data;
            ADDR_INTENSITY: intensity_d  = w_data[3:0];
            ADDR_SCANLIMIT: scan_limit_d = w_data[2:0];
            ADDR_SHUTDOWN:  shutdown_d   = w_data[0];
            ADDR_TEST:      test_d       = w_data[0];
            default: ;      // no-op, 0xD and 0xE: accepted, nothing stored
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = FSM_IDLE;
    endcase
  end

  // Read port, computed from the current register state.
  logic [7:0] w_digit_raw;
  logic [7:0] w_digit_view;

  assign w_digit_raw = digit_q[rd_idx];

  always_comb begin
    w_digit_view = w_digit_raw;
`ifdef MAX7219_CODEB_EN
    if (decode_q[rd_idx]) w_digit_view = {w_digit_raw[7], codeb_font(w_digit_raw[3:0])};
`endif
  end

  always_comb begin
    rd_data_d = w_digit_view;
    if (test_q)                    rd_data_d = 8'hFF;
    else if (!shutdown_q)          rd_data_d = 8'h00;
    else if (rd_idx > scan_limit_q) rd_data_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      flush_q       <= '0;
      state_q       <= FSM_IDLE;
      shift_q       <= '0;
      count_q       <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_q      <= '0;
      intensity_q   <= '0;
      scan_limit_q  <= '0;
      shutdown_q    <= 1'b0;
      test_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      rd_data_q     <= '0;
    end else begin
      flush_q       <= flush_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      digit_q       <= digit_d;
      decode_q      <= decode_d;
      intensity_q   <= intensity_d;
      scan_limit_q  <= scan_limit_d;
      shutdown_q    <= shutdown_d;
      test_q        <= test_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_addr_q  <= frame_addr_d;
      frame_data_q  <= frame_data_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign intensity   = intensity_q;
  assign scan_limit  = scan_limit_q;
  assign shutdown_n  = shutdown_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;

  // Strobes and levels the receiver has no use for; decode mode only feeds
  // the read port when Code-B is compiled in.
  logic w_unused_sigs;
  assign w_unused_sigs = ^{w_mosi_rise, w_mosi_fall, w_cs_lvl, w_sclk_lvl,
                           w_sclk_fall, decode_q};

endmodule
`default_nettype wire
